bus_timer_device: RTL and testbench

- Memory-mapped timer peripheral on the device (responder) side of the single-cycle request bus interconnect.
- Holds a 64-bit free-running counter (mtime), a 64-bit compare value (mtimecmp), a clock prescaler and a registered timer interrupt for the core.
- Accepts a request in one cycle and returns read data on the next cycle, the response timing the interconnect expects.

---
 rtl/bus_timer_device.sv | 149 ++++++++++++++
 tb/tb_bus_timer_device.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_device.sv
// bus_timer_device: memory-mapped 64-bit machine timer (mtime, mtimecmp, prescaler, level irq)
// on the responder side of a single-cycle request bus. Optional macro: BUS_TIMER_HI_LATCH_EN.
module bus_timer_device #(
  parameter int DataWidth     = 32,  // only 32 is supported
  parameter int AddressWidth  = 32,
  parameter int PrescaleWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    timer_irq_o
);

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_PRESCALE    = 3'd5,
    REG_STATUS      = 3'd6,
    REG_RESERVED    = 3'd7
  } reg_e;

  logic [63:0]              r_mtime;
  logic [63:0]              r_mtimecmp;
  logic                     r_enable;
  logic                     r_irq_en;
  logic [PrescaleWidth-1:0] r_prescale;
  logic [PrescaleWidth-1:0] r_prescale_cnt;
  logic [DataWidth-1:0]     r_rdata;
  logic                     r_irq;

  reg_e                     w_offset;
  logic                     w_write;
  logic                     w_read;
  logic                     w_tick;
  logic                     w_cmp_ge;
  logic [63:0]              w_mtime_next;
  logic [PrescaleWidth-1:0] w_prescale_cnt_next;
  logic [DataWidth-1:0]     w_read_value;
  logic [DataWidth-1:0]     w_mtime_hi_view;
  logic                     w_unused_addr;

  // Base/mask decode lives in the interconnect; only the word offset matters here.
  assign w_offset      = reg_e'(device_addr_i[4:2]);
  assign w_unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

  assign w_write  = device_req_i && device_we_i;
  assign w_read   = device_req_i && !device_we_i;
  assign w_tick   = r_enable && (r_prescale_cnt == r_prescale);
  assign w_cmp_ge = (r_mtime >= r_mtimecmp);

  // A bus write to either mtime half wins over a tick in the same cycle: the written
  // half takes the bus value and the other half keeps its pre-increment value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_mtime_next = r_mtime;
    if (w_write && w_offset == REG_MTIME_LO) begin
      w_mtime_next = {r_mtime[63:32], device_wdata_i};
    end else if (w_write && w_offset == REG_MTIME_HI) begin
      w_mtime_next = {device_wdata_i, r_mtime[31:0]};
    end else if (w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
  end

  always_comb begin
    w_prescale_cnt_next = r_prescale_cnt;
    if (w_write && w_offset == REG_PRESCALE) begin
      w_prescale_cnt_next = '0;
    end else if (w_tick) begin
      w_prescale_cnt_next = '0;
    end else if (r_enable) begin
      w_prescale_cnt_next = r_prescale_cnt + PrescaleWidth'(1);
    end
  end

`ifdef BUS_TIMER_HI_LATCH_EN
  logic [31:0] r_mtime_hi_shadow;

  // Reading LO snapshots HI so a LO-then-HI pair is coherent across a carry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime_hi_shadow <= '0;
    end else if (w_read && w_offset == REG_MTIME_LO) begin
      r_mtime_hi_shadow <= r_mtime[63:32];
    end
  end

  assign w_mtime_hi_view = r_mtime_hi_shadow;
`else
  assign w_mtime_hi_view = r_mtime[63:32];
`endif

  always_comb begin
    w_read_value = '0;
    case (w_offset)
      REG_MTIME_LO:    w_read_value = r_mtime[31:0];
      REG_MTIME_HI:    w_read_value = w_mtime_hi_view;
      REG_MTIMECMP_LO: w_read_value = r_mtimecmp[31:0];
      REG_MTIMECMP_HI: w_read_value = r_mtimecmp[63:32];
      REG_CTRL:        w_read_value = DataWidth'({r_irq_en, r_enable});
      REG_PRESCALE:    w_read_value = DataWidth'(r_prescale);
      REG_STATUS:      w_read_value = DataWidth'({r_irq, w_cmp_ge});
      default:         w_read_value = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (rst_i) begin
      r_mtime        <= '0;
      r_mtimecmp     <= '1;
      r_enable       <= 1'b0;
      r_irq_en       <= 1'b0;
      r_prescale     <= '0;
      r_prescale_cnt <= '0;
      r_rdata        <= '0;
      r_irq          <= 1'b0;
    end else begin
      r_mtime        <= w_mtime_next;
      r_prescale_cnt <= w_prescale_cnt_next;
      r_irq          <= r_irq_en && w_cmp_ge;
      r_rdata        <= w_read ? w_read_value : '0;
      if (w_write) begin
        case (w_offset)
          REG_MTIMECMP_LO: r_mtimecmp[31:0]  <= device_wdata_i;
          REG_MTIMECMP_HI: r_mtimecmp[63:32] <= device_wdata_i;
          REG_CTRL: begin
            r_enable <= device_wdata_i[0];
            r_irq_en <= device_wdata_i[1];
          end
          REG_PRESCALE:    r_prescale <= device_wdata_i[PrescaleWidth-1:0];
          default:         ;
        endcase
      end
    end
  end

  assign device_rdata_o = r_rdata;
  assign timer_irq_o    = r_irq;

endmodule

// File: tb/tb_bus_timer_device.sv
// Self-checking bench for bus_timer_device: table-driven register vectors, directed timing
// sequences and randomized traffic compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_bus_timer_device;

  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;
  localparam logic [2:0] OFF_PRESCALE    = 3'd5;
  localparam logic [2:0] OFF_STATUS      = 3'd6;
  localparam logic [2:0] OFF_RESERVED    = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int    checks = 0;
  int    errors = 0;
  string phase = "init";

  always #5 clk = ~clk;

  bus_timer_device #(
    .DataWidth(32),
    .AddressWidth(32),
    .PrescaleWidth(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .device_req_i(req),
    .device_addr_i(addr),
    .device_we_i(we),
    .device_wdata_i(wdata),
    .device_rdata_o(rdata),
    .timer_irq_o(irq)
  );

  // Behavioural model of the programmer-visible state.
  logic [63:0] m_time, m_cmp;
  logic        m_en, m_ie, m_irq;
  logic [15:0] m_ps, m_pc;
  logic [31:0] m_rdata, m_shadow;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      OFF_MTIME_LO:    return m_time[31:0];
`ifdef BUS_TIMER_HI_LATCH_EN
      OFF_MTIME_HI:    return m_shadow;
`else
      OFF_MTIME_HI:    return m_time[63:32];
`endif
      OFF_MTIMECMP_LO: return m_cmp[31:0];
      OFF_MTIMECMP_HI: return m_cmp[63:32];
      OFF_CTRL:        return {30'd0, m_ie, m_en};
      OFF_PRESCALE:    return {16'd0, m_ps};
      OFF_STATUS:      return {30'd0, m_irq, (m_time >= m_cmp)};
      default:         return 32'd0;
    endcase
  endfunction

  function automatic void model_step(input logic r, input logic q, input logic w,
                                     input logic [2:0] off, input logic [31:0] d);
    logic        ge;
    logic        tick;
    logic [31:0] rv;
    logic [63:0] nt;
    if (r) begin
      m_time = '0; m_cmp = '1; m_en = 1'b0; m_ie = 1'b0; m_ps = '0; m_pc = '0;
      m_rdata = '0; m_irq = 1'b0; m_shadow = '0;
      return;
    end
    ge   = (m_time >= m_cmp);
    rv   = model_read(off);
    tick = m_en && (m_pc == m_ps);
    nt   = tick ? m_time + 64'd1 : m_time;
    if (m_en) m_pc = tick ? 16'd0 : m_pc + 16'd1;
    m_irq   = m_ie && ge;
    m_rdata = (q && !w) ? rv : 32'd0;
    if (q && !w && off == OFF_MTIME_LO) m_shadow = m_time[63:32];
    if (q && w) begin
      case (off)
        OFF_MTIME_LO:    nt = {m_time[63:32], d};
        OFF_MTIME_HI:    nt = {d, m_time[31:0]};
        OFF_MTIMECMP_LO: m_cmp[31:0] = d;
        OFF_MTIMECMP_HI: m_cmp[63:32] = d;
        OFF_CTRL:        begin m_en = d[0]; m_ie = d[1]; end
        OFF_PRESCALE:    begin m_ps = d[15:0]; m_pc = '0; end
        default:         ;
      endcase
    end
    m_time = nt;
  endfunction

  // One bus cycle: drive, advance the model, clock, then compare outputs #1 after the edge.
  task automatic step(input logic r, input logic q, input logic w,
                      input logic [2:0] off, input logic [31:0] d);
    logic [31:0] a;
    rst   = r;
    req   = q;
    we    = w;
    a     = $urandom;
    a[4:2] = off;
    addr  = a;
    wdata = d;
    model_step(r, q, w, off, d);
    @(posedge clk);
    #1;
    check({phase, " rdata"}, rdata, m_rdata);
    check({phase, " irq"}, irq, m_irq);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, off, d);
  endtask

  task automatic rd(input logic [2:0] off);
    step(1'b0, 1'b1, 1'b0, off, $urandom);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        tbl[24];
    logic [31:0] a_val;
    logic [2:0]  off;
    logic [31:0] d;

    // Reset values after the first reset, and register readback with counting disabled.
    tbl[0]  = '{1'b0, OFF_MTIME_LO,    32'h0,        32'h0};
    tbl[1]  = '{1'b0, OFF_MTIME_HI,    32'h0,        32'h0};
    tbl[2]  = '{1'b0, OFF_MTIMECMP_LO, 32'h0,        32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, OFF_MTIMECMP_HI, 32'h0,        32'hFFFF_FFFF};
    tbl[4]  = '{1'b0, OFF_CTRL,        32'h0,        32'h0};
    tbl[5]  = '{1'b0, OFF_PRESCALE,    32'h0,        32'h0};
    tbl[6]  = '{1'b0, OFF_STATUS,      32'h0,        32'h0};
    tbl[7]  = '{1'b0, OFF_RESERVED,    32'h0,        32'h0};
    tbl[8]  = '{1'b1, OFF_MTIMECMP_LO, 32'h1234_5678, 32'h0};
    tbl[9]  = '{1'b0, OFF_MTIMECMP_LO, 32'h0,        32'h1234_5678};
    tbl[10] = '{1'b1, OFF_CTRL,        32'hFFFF_FFFC, 32'h0};
    tbl[11] = '{1'b0, OFF_CTRL,        32'h0,        32'h0};
    tbl[12] = '{1'b1, OFF_PRESCALE,    32'hABCD_1234, 32'h0};
    tbl[13] = '{1'b0, OFF_PRESCALE,    32'h0,        32'h0000_1234};
    tbl[14] = '{1'b1, OFF_RESERVED,    32'hDEAD_BEEF, 32'h0};
    tbl[15] = '{1'b0, OFF_RESERVED,    32'h0,        32'h0};
    tbl[16] = '{1'b1, OFF_STATUS,      32'hFFFF_FFFF, 32'h0};
    tbl[17] = '{1'b0, OFF_STATUS,      32'h0,        32'h0};
    tbl[18] = '{1'b1, OFF_MTIME_HI,    32'h0000_000A, 32'h0};
    tbl[19] = '{1'b0, OFF_MTIME_LO,    32'h0,        32'h0};
    tbl[20] = '{1'b0, OFF_MTIME_HI,    32'h0,        32'h0000_000A};
    tbl[21] = '{1'b1, OFF_MTIMECMP_LO, 32'hFFFF_FFFF, 32'h0};
    tbl[22] = '{1'b1, OFF_PRESCALE,    32'h0,        32'h0};
    tbl[23] = '{1'b1, OFF_MTIME_HI,    32'h0,        32'h0};

    // Two reset cycles; the first also carries a write that must be discarded.
    phase = "reset";
    step(1'b1, 1'b1, 1'b1, OFF_MTIME_LO, 32'h0000_1234);
    step(1'b1, 1'b0, 1'b0, OFF_MTIME_LO, 32'h0);
    check("reset irq", irq, 1'b0);
    check("reset rdata", rdata, 32'h0);

    phase = "table";
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1, tbl[i].we, tbl[i].off, tbl[i].wdata);
      check($sformatf("tbl[%0d] off%0d", i, tbl[i].off), rdata, tbl[i].exp);
    end

    // Prescale 3: one increment per four enabled cycles.
    phase = "prescale3";
    wr(OFF_PRESCALE, 32'd3);
    wr(OFF_CTRL, 32'd1);
    repeat (39) idle();
    rd(OFF_MTIME_LO);
    check("prescale3 count in 9..11", (rdata >= 32'd9 && rdata <= 32'd11), 1'b1);

    phase = "prescale0";
    wr(OFF_PRESCALE, 32'd0);
    wr(OFF_MTIME_LO, 32'd0);
    repeat (39) idle();
    rd(OFF_MTIME_LO);
    check("prescale0 count in 39..41", (rdata >= 32'd39 && rdata <= 32'd41), 1'b1);

    phase = "freeze";
    wr(OFF_CTRL, 32'd0);
    rd(OFF_MTIME_LO);
    a_val = rdata;
    repeat (20) idle();
    rd(OFF_MTIME_LO);
    check("freeze equal reads", rdata, a_val);

    // Interrupt rises exactly one cycle after mtime reaches 100.
    phase = "irq";
    wr(OFF_MTIME_LO, 32'd0);
    wr(OFF_MTIMECMP_HI, 32'd0);
    wr(OFF_MTIMECMP_LO, 32'd100);
    wr(OFF_PRESCALE, 32'd0);
    wr(OFF_CTRL, 32'd3);
    for (int i = 1; i <= 101; i++) begin
      if (i == 101) rd(OFF_MTIME_LO);
      else idle();
      if (i == 100) check("irq low as mtime hits 100", irq, 1'b0);
    end
    check("irq high one cycle later", irq, 1'b1);
    check("mtime sampled at irq rise", rdata, 32'd100);
    rd(OFF_STATUS);
    check("status with irq", rdata, 32'h3);
    wr(OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
    check("irq still high on cmp write", irq, 1'b1);
    idle();
    check("irq falls after cmp raised", irq, 1'b0);

    // 64-bit wrap.
    phase = "wrap";
    wr(OFF_CTRL, 32'd0);
    wr(OFF_MTIME_HI, 32'hFFFF_FFFF);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFE);
    wr(OFF_CTRL, 32'd1);
    rd(OFF_MTIME_LO);
    check("wrap lo pre", rdata, 32'hFFFF_FFFE);
    rd(OFF_MTIME_HI);
    check("wrap hi at max", rdata, 32'hFFFF_FFFF);
    rd(OFF_MTIME_LO);
    check("wrap lo zero", rdata, 32'h0);
    rd(OFF_MTIME_HI);
    check("wrap hi zero", rdata, 32'h0);

    // LO->HI carry, and the HI shadow behaviour.
    phase = "carry";
    wr(OFF_CTRL, 32'd0);
    wr(OFF_MTIME_HI, 32'h0);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
    wr(OFF_CTRL, 32'd1);
    rd(OFF_MTIME_LO);
    check("carry lo before", rdata, 32'hFFFF_FFFF);
    rd(OFF_MTIME_HI);
`ifdef BUS_TIMER_HI_LATCH_EN
    check("carry hi latched", rdata, 32'h0);
`else
    check("carry hi live", rdata, 32'h1);
`endif
    rd(OFF_MTIME_LO);
    check("carry lo after", rdata, 32'h1);
    rd(OFF_MTIME_HI);
    check("carry hi after", rdata, 32'h1);

    // Write in a tick cycle, then reset colliding with a write.
    phase = "collision";
    wr(OFF_MTIME_LO, 32'h55);
    repeat (5) idle();
    rd(OFF_MTIME_LO);
    check("collision lo", rdata, 32'h5A);
    step(1'b1, 1'b1, 1'b1, OFF_CTRL, 32'h3);
    rd(OFF_CTRL);
    check("reset beats ctrl write", rdata, 32'h0);
    rd(OFF_MTIME_LO);
    check("reset clears mtime", rdata, 32'h0);

    // Randomized traffic against the model.
    phase = "rand";
    for (int i = 0; i < 4000; i++) begin
      off = 3'($urandom_range(0, 7));
      d   = $urandom;
      if (off == OFF_PRESCALE) d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
      if ((off == OFF_MTIME_LO || off == OFF_MTIME_HI) && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF;
      if ((off == OFF_MTIMECMP_LO || off == OFF_MTIMECMP_HI) && $urandom_range(0, 1) == 0)
        d = 32'($urandom_range(0, 300));
      if (off == OFF_CTRL && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), off, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
